// File: rtl/jump_control_unit.sv
// Jump resolution for decode: J/JAL/JR/JALR redirect, link write,
// shadow-cycle kill and a circular return-address stack with profiling counters.
module jump_control_unit #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         stall,
    input  logic [5:0]                   opcode,
    input  logic [1:0]                   alu_op,
    input  logic [5:0]                   fn,
    input  logic [4:0]                   rs_num,
    input  logic [4:0]                   rd_num,
    input  logic [25:0]                  instr_index,
    input  logic [ADDR_W-1:0]            pc_plus4,
    input  logic [ADDR_W-1:0]            rs_value,
    output logic                         jr_control,
    output logic                         redirect_valid,
    output logic [ADDR_W-1:0]            redirect_pc,
    output logic                         link_we,
    output logic [4:0]                   link_reg,
    output logic [ADDR_W-1:0]            link_data,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SHADOW = 1'b1;

    logic [0:0]        state;
    logic [PW-1:0]     ptr;
    logic [ADDR_W-1:0] stack [RAS_DEPTH];

    logic is_r, is_j, is_jal, is_jr, is_jalr, is_jump;
    logic accept, take, push, pop_ra, empty;
    logic [ADDR_W-1:0] target;
    logic [PW-1:0]     ptr_up;

    assign is_r    = (opcode == 6'h00) && (alu_op == 2'b10);
    assign is_j    = (opcode == 6'h02);
    assign is_jal  = (opcode == 6'h03);
    assign is_jr   = is_r && (fn == 6'h08);
    assign is_jalr = is_r && (fn == 6'h09);
    assign is_jump = is_j | is_jal | is_jr | is_jalr;

    assign jr_control = (alu_op == 2'b10) && (fn == 6'h08);

    assign accept = valid_in && !stall && (state == ST_IDLE);
    assign take   = accept && is_jump;
    assign push   = accept && (is_jal || is_jalr);
    assign pop_ra = accept && is_jr && (rs_num == 5'd31);
    assign empty  = (ras_count == '0);
    assign ptr_up = ptr + 1'b1;

    assign ras_top = empty ? '0 : stack[ptr];

    // Region bits above 27 come from the sequential PC; low 28 from the index.
    always_comb begin
        target = rs_value;
        if (is_j || is_jal) begin
            target       = pc_plus4;
            target[27:0] = {instr_index, 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            link_we        <= 1'b0;
            link_reg       <= '0;
            link_data      <= '0;
            ptr            <= '0;
            ras_count      <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
        end else begin
            redirect_valid <= take;
            link_we        <= accept && (is_jal || (is_jalr && rd_num != 5'd0));
            if (take) redirect_pc <= target;
            if (push) begin
                link_reg  <= is_jal ? 5'd31 : rd_num;
                link_data <= pc_plus4;
            end

            case (state)
                ST_IDLE:   if (take) state <= ST_SHADOW;
                ST_SHADOW: if (!stall) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            // Full stack: the oldest slot is the one after top, so it is overwritten.
            if (push) begin
                stack[ptr_up] <= pc_plus4;
                ptr           <= ptr_up;
                if (ras_count != FULL) ras_count <= ras_count + 1'b1;
            end else if (pop_ra) begin
                if (!empty) begin
                    ptr       <= ptr - 1'b1;
                    ras_count <= ras_count - 1'b1;
                end
                if (!empty && ras_top == rs_value) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jump_control_unit.sv
// Directed bench for jump_control_unit: vector table plus stall,
// saturation and asynchronous-reset sequences.
module tb_jump_control_unit;

    localparam int K_NOP  = 0;
    localparam int K_J    = 1;
    localparam int K_JAL  = 2;
    localparam int K_JRRA = 3;
    localparam int K_JR   = 4;
    localparam int K_JALR = 5;
    localparam int K_LW   = 6;
    localparam int K_ADD  = 7;
    localparam int K_JRC  = 8;

    logic        clk = 0;
    logic        rst;
    logic        valid_in, stall;
    logic [5:0]  opcode, fn;
    logic [1:0]  alu_op;
    logic [4:0]  rs_num, rd_num;
    logic [25:0] instr_index;
    logic [31:0] pc_plus4, rs_value;
    logic        jr_control, redirect_valid, link_we;
    logic [31:0] redirect_pc, link_data, ras_top;
    logic [4:0]  link_reg;
    logic [2:0]  ras_count, hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    jump_control_unit #(.ADDR_W(32), .RAS_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .opcode(opcode), .alu_op(alu_op), .fn(fn), .rs_num(rs_num),
        .rd_num(rd_num), .instr_index(instr_index), .pc_plus4(pc_plus4),
        .rs_value(rs_value), .jr_control(jr_control),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .link_we(link_we), .link_reg(link_reg), .link_data(link_data),
        .ras_top(ras_top), .ras_count(ras_count),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, stall;
        logic [5:0]  op, fn;
        logic [1:0]  alu;
        logic [4:0]  rs, rd;
        logic [25:0] idx;
        logic [31:0] pc4, rsv;
        logic        jr, rv, lwe;
        logic [31:0] rpc, ldata, top;
        logic [4:0]  lreg;
        logic [2:0]  cnt, hit, miss;
        logic        chk_pc, chk_link;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int k, input logic [31:0] pc4,
                                input logic [31:0] arg, input logic [4:0] rd,
                                input logic [2:0] ecnt, input logic [31:0] etop,
                                input logic [2:0] ehit, input logic [2:0] emiss,
                                input logic erv, input logic elwe);
        vec_t v;
        v = '{default: '0};
        v.valid = 1'b1;
        v.pc4 = pc4;
        v.rd = rd;
        case (k)
            K_NOP:  v.valid = 1'b0;
            K_J:    begin v.op = 6'h02; v.idx = arg[25:0]; end
            K_JAL:  begin v.op = 6'h03; v.idx = arg[25:0]; end
            K_JRRA: begin v.alu = 2'b10; v.fn = 6'h08; v.rs = 5'd31; v.rsv = arg; end
            K_JR:   begin v.alu = 2'b10; v.fn = 6'h08; v.rs = 5'd2; v.rsv = arg; end
            K_JALR: begin v.alu = 2'b10; v.fn = 6'h09; v.rs = 5'd3; v.rsv = arg; end
            K_LW:   v.op = 6'h23;
            K_ADD:  begin v.alu = 2'b10; v.fn = 6'h20; end
            K_JRC:  begin v.valid = 1'b0; v.alu = 2'b10; v.fn = 6'h08; end
            default: v.valid = 1'b0;
        endcase
        v.jr = (k == K_JRRA) || (k == K_JR) || (k == K_JRC);
        v.cnt = ecnt; v.top = etop; v.hit = ehit; v.miss = emiss;
        v.rv = erv; v.lwe = elwe;
        return v;
    endfunction

    function automatic vec_t wpc(input vec_t v, input logic [31:0] pc);
        vec_t r = v;
        r.chk_pc = 1'b1; r.rpc = pc;
        return r;
    endfunction

    function automatic vec_t wlink(input vec_t v, input logic [4:0] lr, input logic [31:0] ld);
        vec_t r = v;
        r.chk_link = 1'b1; r.lreg = lr; r.ldata = ld;
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_in = v.valid; stall = v.stall; opcode = v.op; alu_op = v.alu;
        fn = v.fn; rs_num = v.rs; rd_num = v.rd; instr_index = v.idx;
        pc_plus4 = v.pc4; rs_value = v.rsv;
    endtask

    // Drive at negedge, sample just after the following posedge.
    task automatic step(input int k, input logic [31:0] pc4, input logic [31:0] arg, input logic st);
        vec_t v;
        v = mk(k, pc4, arg, 5'd31, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        v.stall = st;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // J, then JAL in the shadow cycle must be discarded
        vecs.push_back(wpc(mk(K_J, 32'h0040_0004, 32'h100, 5'd31, 0, 0, 0, 0, 1, 0), 32'h400));
        vecs.push_back(wpc(mk(K_JAL, 32'h200, 32'h80, 5'd31, 0, 0, 0, 0, 0, 0), 32'h400));
        v = mk(K_JAL, 32'h100, 32'h40, 5'd31, 1, 32'h100, 0, 0, 1, 1);
        vecs.push_back(wlink(wpc(v, 32'h100), 5'd31, 32'h100));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0));
        v = mk(K_JRRA, 0, 32'h100, 0, 0, 0, 1, 0, 1, 0);
        vecs.push_back(wlink(wpc(v, 32'h100), 5'd31, 32'h100));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // Five pushes into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            logic [2:0] c;
            c = (i > 4) ? 3'd4 : 3'(i);
            v = mk(K_JAL, 32'(i * 16), 32'(i * 4), 5'd31, c, 32'(i * 16), 1, 0, 1, 1);
            vecs.push_back(wlink(wpc(v, 32'(i * 16)), 5'd31, 32'(i * 16)));
            vecs.push_back(mk(K_NOP, 0, 0, 0, c, 32'(i * 16), 1, 0, 0, 0));
        end
        // Four matching pops: 0x50,0x40,0x30,0x20
        for (int j = 0; j < 4; j++) begin
            logic [31:0] val, tp;
            val = 32'h50 - 32'(16 * j);
            tp  = (j == 3) ? 32'h0 : val - 32'h10;
            v = mk(K_JRRA, 0, val, 0, 3'(3 - j), tp, 3'(2 + j), 0, 1, 0);
            vecs.push_back(wpc(v, val));
            vecs.push_back(mk(K_NOP, 0, 0, 0, 3'(3 - j), tp, 3'(2 + j), 0, 0, 0));
        end
        // Pops on an empty stack count as misses
        vecs.push_back(wpc(mk(K_JRRA, 0, 32'h10, 0, 0, 0, 5, 1, 1, 0), 32'h10));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 0, 0, 5, 1, 0, 0));
        vecs.push_back(mk(K_JRRA, 0, 32'h10, 0, 0, 0, 5, 2, 1, 0));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 0, 0, 5, 2, 0, 0));
        // JALR to $0: redirect and push, no link write
        vecs.push_back(wpc(mk(K_JALR, 32'h300, 32'h1234, 5'd0, 1, 32'h300, 5, 2, 1, 0), 32'h1234));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 1, 32'h300, 5, 2, 0, 0));
        // JR through a non-$ra register leaves the stack alone
        vecs.push_back(wpc(mk(K_JR, 0, 32'h2000, 0, 1, 32'h300, 5, 2, 1, 0), 32'h2000));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 1, 32'h300, 5, 2, 0, 0));
        v = mk(K_JALR, 32'h304, 32'h3000, 5'd7, 2, 32'h304, 5, 2, 1, 1);
        vecs.push_back(wlink(wpc(v, 32'h3000), 5'd7, 32'h304));
        vecs.push_back(mk(K_NOP, 0, 0, 0, 2, 32'h304, 5, 2, 0, 0));
        // Non-jumps and jr_control with valid_in low
        vecs.push_back(wpc(mk(K_LW, 32'h400, 0, 0, 2, 32'h304, 5, 2, 0, 0), 32'h3000));
        vecs.push_back(mk(K_ADD, 32'h404, 0, 0, 2, 32'h304, 5, 2, 0, 0));
        vecs.push_back(mk(K_JRC, 0, 32'h9999, 0, 2, 32'h304, 5, 2, 0, 0));

        rst = 1'b1;
        drive(mk(K_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rv", 0, 32'(redirect_valid), 0);
        chk("rst_lwe", 0, 32'(link_we), 0);
        chk("rst_rpc", 0, redirect_pc, 0);
        chk("rst_lreg", 0, 32'(link_reg), 0);
        chk("rst_ldata", 0, link_data, 0);
        chk("rst_cnt", 0, 32'(ras_count), 0);
        chk("rst_top", 0, ras_top, 0);
        chk("rst_hit", 0, 32'(hit_cnt), 0);
        chk("rst_miss", 0, 32'(miss_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk("jr_control", i, 32'(jr_control), 32'(vecs[i].jr));
            @(posedge clk);
            #1;
            chk("redirect_valid", i, 32'(redirect_valid), 32'(vecs[i].rv));
            chk("link_we", i, 32'(link_we), 32'(vecs[i].lwe));
            chk("ras_count", i, 32'(ras_count), 32'(vecs[i].cnt));
            chk("ras_top", i, ras_top, vecs[i].top);
            chk("hit_cnt", i, 32'(hit_cnt), 32'(vecs[i].hit));
            chk("miss_cnt", i, 32'(miss_cnt), 32'(vecs[i].miss));
            if (vecs[i].chk_pc) chk("redirect_pc", i, redirect_pc, vecs[i].rpc);
            if (vecs[i].chk_link) begin
                chk("link_reg", i, 32'(link_reg), 32'(vecs[i].lreg));
                chk("link_data", i, link_data, vecs[i].ldata);
            end
        end

        // Stall after an accepted JR: one pulse, shadow holds, first free cycle killed
        step(K_JR, 0, 32'h4444, 1'b0);
        chk("stall_rv0", 0, 32'(redirect_valid), 1);
        chk("stall_pc", 0, redirect_pc, 32'h4444);
        for (int s = 1; s <= 3; s++) begin
            step(K_JAL, 32'h600, 32'h180, 1'b1);
            chk("stall_rv", s, 32'(redirect_valid), 0);
            chk("stall_cnt", s, 32'(ras_count), 2);
        end
        step(K_JAL, 32'h600, 32'h180, 1'b0);
        chk("shadow_kill_rv", 0, 32'(redirect_valid), 0);
        chk("shadow_kill_cnt", 0, 32'(ras_count), 2);
        step(K_JAL, 32'h600, 32'h180, 1'b0);
        chk("post_shadow_rv", 0, 32'(redirect_valid), 1);
        chk("post_shadow_cnt", 0, 32'(ras_count), 3);
        chk("post_shadow_top", 0, ras_top, 32'h600);
        step(K_NOP, 0, 0, 1'b0);

        // Hit counter saturates at 7 with a 3-bit width
        step(K_JRRA, 0, 32'h600, 1'b0);
        chk("sat_hit6", 0, 32'(hit_cnt), 6);
        step(K_NOP, 0, 0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            step(K_JAL, 32'h500, 32'h140, 1'b0);
            step(K_NOP, 0, 0, 1'b0);
            step(K_JRRA, 0, 32'h500, 1'b0);
            chk("sat_hit7", s, 32'(hit_cnt), 7);
            chk("sat_miss", s, 32'(miss_cnt), 2);
            step(K_NOP, 0, 0, 1'b0);
        end

        // Asynchronous reset while a redirect pulse is live
        step(K_JAL, 32'h700, 32'h1c0, 1'b0);
        chk("pre_rst_rv", 0, 32'(redirect_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rv", 0, 32'(redirect_valid), 0);
        chk("async_rst_lwe", 0, 32'(link_we), 0);
        chk("async_rst_cnt", 0, 32'(ras_count), 0);
        chk("async_rst_hit", 0, 32'(hit_cnt), 0);
        chk("async_rst_top", 0, ras_top, 0);
        @(posedge clk);
        #1;
        chk("held_rst_rv", 0, 32'(redirect_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_rv", 0, 32'(redirect_valid), 1);
        chk("after_rst_cnt", 0, 32'(ras_count), 1);
        chk("after_rst_pc", 0, redirect_pc, 32'h700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
